// File: rtl/stall_ctrl.sv
// Pipeline hazard controller: arbitrates IF/ID/MEM stall requests into a per-stage
// stall vector and sequences branch redirects so that the PC is never reloaded while
// IF still has a memory fetch in flight. Also keeps saturating stall/flush counters.
module stall_ctrl #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  stall_req_if,
    input  logic                  stall_req_id,
    input  logic                  stall_req_mem,
    input  logic                  branch_req,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    input  logic                  if_busy,
    output logic [5:0]            stall_out,
    output logic                  branch_or_not,
    output logic                  pc_redirect_valid,
    output logic [ADDR_WIDTH-1:0] pc_redirect,
    output logic [CNT_WIDTH-1:0]  stall_cycles,
    output logic [CNT_WIDTH-1:0]  flush_count
);

    typedef enum logic [0:0] {
        StRun,
        StFlushWait
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] target_q, target_d;
    logic [CNT_WIDTH-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0]  flush_cnt_q, flush_cnt_d;

    logic                  accept;
    logic                  in_flush;
    logic [5:0]            stall_raw;
    logic                  flush_raw;
    logic                  redirect_raw;
    logic [ADDR_WIDTH-1:0] redirect_pc_raw;

    // Stall vector priority, branch acceptance and redirect generation.
    always_comb begin
        // EX is frozen under a MEM stall, so a branch seen then is dropped and re-presented.
        accept   = rdy_in & ~stall_req_mem & branch_req;
        in_flush = (state_q == StFlushWait);

        if (!rdy_in) begin
            stall_raw = 6'b111111;
        end else if (stall_req_mem) begin
            stall_raw = 6'b011111;
        end else if (stall_req_id) begin
            stall_raw = 6'b000111;
        end else if (stall_req_if) begin
            stall_raw = 6'b000011;
        end else begin
            stall_raw = 6'b000000;
        end

        flush_raw       = rdy_in & (accept | in_flush);
        // Redirect only once IF has no fetch outstanding; a newer branch wins immediately.
        redirect_raw    = rdy_in & ~if_busy & (accept | in_flush);
        redirect_pc_raw = accept ? branch_target : target_q;

        // Outputs are forced quiet while reset is held, independent of the clock.
        stall_out         = rst_in ? stall_raw : 6'b000000;
        branch_or_not     = rst_in & flush_raw;
        pc_redirect_valid = rst_in & redirect_raw;
        pc_redirect       = rst_in ? redirect_pc_raw : '0;
        stall_cycles      = stall_cnt_q;
        flush_count       = flush_cnt_q;
    end

    // Next-state for the redirect FSM, the latched target and the saturating counters.
    always_comb begin
        state_d     = state_q;
        target_d    = accept ? branch_target : target_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        if (rdy_in) begin
            if (redirect_raw) begin
                state_d = StRun;
            end else if (accept && if_busy) begin
                state_d = StFlushWait;
            end

            if ((stall_raw != 6'b000000) && !(&stall_cnt_q)) begin
                stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
            end
            if (redirect_raw && !(&flush_cnt_q)) begin
                flush_cnt_d = flush_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    // State registers; async reset discards any pending redirect.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= StRun;
            target_q    <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

endmodule

// File: tb/tb_stall_ctrl.sv
// Scoreboard bench for stall_ctrl: the driver pushes hand-computed expectations per cycle,
// a negedge monitor pops and compares against a full-width DUT and a 4-bit-counter DUT.
module tb_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        stall_req_if;
    logic        stall_req_id;
    logic        stall_req_mem;
    logic        branch_req;
    logic [31:0] branch_target;
    logic        if_busy;

    logic [5:0]  stall_out;
    logic        branch_or_not;
    logic        pc_redirect_valid;
    logic [31:0] pc_redirect;
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;

    logic [5:0]  s_stall_out;
    logic        s_branch_or_not;
    logic        s_pc_redirect_valid;
    logic [31:0] s_pc_redirect;
    logic [3:0]  s_stall_cycles;
    logic [3:0]  s_flush_count;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        int          idx;
        logic [5:0]  stall;
        logic        bon;
        logic        prv;
        logic [31:0] pcr;
        bit          chk_cnt;
        int          sc;
        int          fc;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;

    always #5 clk = ~clk;

    stall_ctrl #(
        .ADDR_WIDTH(32),
        .CNT_WIDTH (32)
    ) u_dut (
        .clk_in           (clk),
        .rst_in           (rst_in),
        .rdy_in           (rdy_in),
        .stall_req_if     (stall_req_if),
        .stall_req_id     (stall_req_id),
        .stall_req_mem    (stall_req_mem),
        .branch_req       (branch_req),
        .branch_target    (branch_target),
        .if_busy          (if_busy),
        .stall_out        (stall_out),
        .branch_or_not    (branch_or_not),
        .pc_redirect_valid(pc_redirect_valid),
        .pc_redirect      (pc_redirect),
        .stall_cycles     (stall_cycles),
        .flush_count      (flush_count)
    );

    // Narrow counters so saturation is reachable in a short run.
    stall_ctrl #(
        .ADDR_WIDTH(32),
        .CNT_WIDTH (4)
    ) u_dut_sat (
        .clk_in           (clk),
        .rst_in           (rst_in),
        .rdy_in           (rdy_in),
        .stall_req_if     (stall_req_if),
        .stall_req_id     (stall_req_id),
        .stall_req_mem    (stall_req_mem),
        .branch_req       (branch_req),
        .branch_target    (branch_target),
        .if_busy          (if_busy),
        .stall_out        (s_stall_out),
        .branch_or_not    (s_branch_or_not),
        .pc_redirect_valid(s_pc_redirect_valid),
        .pc_redirect      (s_pc_redirect),
        .stall_cycles     (s_stall_cycles),
        .flush_count      (s_flush_count)
    );

    task automatic chk(input string name, input int idx, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL c%0d %s: got %0h expected %0h", idx, name, act, exp);
        end
    endtask

    // Monitor: every cycle the DUT presents outputs; compare with the oldest expectation.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("stall_out", e.idx, 64'(stall_out), 64'(e.stall));
            chk("branch_or_not", e.idx, 64'(branch_or_not), 64'(e.bon));
            chk("pc_redirect_valid", e.idx, 64'(pc_redirect_valid), 64'(e.prv));
            chk("pc_redirect", e.idx, 64'(pc_redirect), 64'(e.pcr));
            chk("sat.stall_out", e.idx, 64'(s_stall_out), 64'(e.stall));
            chk("sat.branch_or_not", e.idx, 64'(s_branch_or_not), 64'(e.bon));
            chk("sat.pc_redirect_valid", e.idx, 64'(s_pc_redirect_valid), 64'(e.prv));
            chk("sat.pc_redirect", e.idx, 64'(s_pc_redirect), 64'(e.pcr));
            if (e.chk_cnt) begin
                chk("stall_cycles", e.idx, 64'(stall_cycles), 64'(e.sc));
                chk("flush_count", e.idx, 64'(flush_count), 64'(e.fc));
                chk("sat.stall_cycles", e.idx, 64'(s_stall_cycles),
                    64'((e.sc > 15) ? 15 : e.sc));
                chk("sat.flush_count", e.idx, 64'(s_flush_count),
                    64'((e.fc > 15) ? 15 : e.fc));
            end
        end
    end

    // Drive one cycle of inputs just after the edge and queue the expected response.
    task automatic step(input bit rst, input bit rdy, input bit sif, input bit sid,
                        input bit smem, input bit br, input logic [31:0] tgt, input bit busy,
                        input logic [5:0] es, input bit ebon, input bit eprv,
                        input logic [31:0] epcr, input bit cc, input int esc, input int efc,
                        input bit late_rst);
        exp_t x;
        rst_in        = rst;
        rdy_in        = rdy;
        stall_req_if  = sif;
        stall_req_id  = sid;
        stall_req_mem = smem;
        branch_req    = br;
        branch_target = tgt;
        if_busy       = busy;
        x.idx     = cyc;
        x.stall   = es;
        x.bon     = ebon;
        x.prv     = eprv;
        x.pcr     = epcr;
        x.chk_cnt = cc;
        x.sc      = esc;
        x.fc      = efc;
        exp_q.push_back(x);
        cyc++;
        if (late_rst) begin
            #2 rst_in = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_in        = 1'b0;
        rdy_in        = 1'b0;
        stall_req_if  = 1'b0;
        stall_req_id  = 1'b0;
        stall_req_mem = 1'b0;
        branch_req    = 1'b0;
        branch_target = '0;
        if_busy       = 1'b0;
        @(posedge clk);
        #1;
        // rst rdy if id mem br tgt busy | stall bon prv pcr | cc sc fc | late_rst
        step(0, 1, 1, 0, 0, 1, 32'h1234, 0, 6'h00, 0, 0, 32'h0, 1, 0, 0, 0);
        // Stall priority
        step(1, 1, 0, 0, 0, 0, 32'h0, 0, 6'h00, 0, 0, 32'h0, 1, 0, 0, 0);
        step(1, 1, 1, 0, 0, 0, 32'h0, 0, 6'h03, 0, 0, 32'h0, 0, 0, 0, 0);
        step(1, 1, 0, 1, 0, 0, 32'h0, 0, 6'h07, 0, 0, 32'h0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 1, 0, 32'h0, 0, 6'h1F, 0, 0, 32'h0, 0, 0, 0, 0);
        step(1, 1, 1, 1, 1, 0, 32'h0, 0, 6'h1F, 0, 0, 32'h0, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0, 32'h0, 0, 6'h3F, 0, 0, 32'h0, 1, 4, 0, 0);
        step(1, 1, 0, 0, 0, 0, 32'h0, 0, 6'h00, 0, 0, 32'h0, 1, 4, 0, 0);
        // Zero-latency redirect
        step(1, 1, 0, 0, 0, 1, 32'h1000, 0, 6'h00, 1, 1, 32'h1000, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 32'h0, 0, 6'h00, 0, 0, 32'h1000, 1, 4, 1, 0);
        // Redirect deferred while IF busy
        step(1, 1, 0, 0, 0, 1, 32'h2000, 1, 6'h00, 1, 0, 32'h2000, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 32'h0, 1, 6'h00, 1, 0, 32'h2000, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 32'h0, 1, 6'h00, 1, 0, 32'h2000, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 32'h0, 1, 6'h00, 1, 0, 32'h2000, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 32'h0, 0, 6'h00, 1, 1, 32'h2000, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 32'h0, 0, 6'h00, 0, 0, 32'h2000, 1, 4, 2, 0);
        // Latest branch wins while waiting
        step(1, 1, 0, 0, 0, 1, 32'h2500, 1, 6'h00, 1, 0, 32'h2500, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 1, 32'h3000, 1, 6'h00, 1, 0, 32'h3000, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 32'h0, 1, 6'h00, 1, 0, 32'h3000, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 32'h0, 0, 6'h00, 1, 1, 32'h3000, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 32'h0, 0, 6'h00, 0, 0, 32'h3000, 1, 4, 3, 0);
        // Branch dropped under MEM stall, and under rdy_in=0
        step(1, 1, 0, 0, 1, 1, 32'h4000, 0, 6'h1F, 0, 0, 32'h3000, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 32'h0, 0, 6'h00, 0, 0, 32'h3000, 1, 5, 3, 0);
        step(1, 0, 0, 0, 0, 1, 32'h5000, 0, 6'h3F, 0, 0, 32'h3000, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 32'h0, 0, 6'h00, 0, 0, 32'h3000, 1, 5, 3, 0);
        // New branch in FLUSH_WAIT with IF going idle the same cycle
        step(1, 1, 0, 0, 0, 1, 32'h6000, 1, 6'h00, 1, 0, 32'h6000, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 1, 32'h7000, 0, 6'h00, 1, 1, 32'h7000, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 32'h0, 0, 6'h00, 0, 0, 32'h7000, 1, 5, 4, 0);
        // Async reset mid-FLUSH_WAIT
        step(1, 1, 0, 0, 0, 1, 32'h8000, 1, 6'h00, 1, 0, 32'h8000, 0, 0, 0, 0);
        step(1, 1, 1, 0, 0, 1, 32'h9000, 1, 6'h00, 0, 0, 32'h0, 1, 0, 0, 1);
        step(0, 1, 1, 0, 0, 1, 32'h9000, 1, 6'h00, 0, 0, 32'h0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 32'h0, 0, 6'h00, 0, 0, 32'h0, 1, 0, 0, 0);
        // Saturation: 18 stall cycles overflow the 4-bit counter
        for (int i = 0; i < 18; i++) begin
            step(1, 1, 1, 0, 0, 0, 32'h0, 0, 6'h03, 0, 0, 32'h0, 0, 0, 0, 0);
        end
        step(1, 1, 0, 0, 0, 0, 32'h0, 0, 6'h00, 0, 0, 32'h0, 1, 18, 0, 0);
        step(1, 1, 1, 0, 0, 0, 32'h0, 0, 6'h03, 0, 0, 32'h0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 32'h0, 0, 6'h00, 0, 0, 32'h0, 1, 19, 0, 0);
        repeat (3) @(posedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
